// File: rtl/keypad_if.sv
// Keypad-side signal bundle for keypad_entry.
// The scanner (master) drives the row lines and publishes the entered value
// and key events; the keypad/consumer side (slave) returns the column lines.
interface keypad_if;
    logic [3:0]  col;        // active-low columns from the keypad
    logic [3:0]  row;        // active-low row drive, one bit low at a time
    logic [13:0] num;        // entered decimal value, 0..9999
    logic        key_valid;  // one-cycle pulse per accepted keypress
    logic [3:0]  key_code;   // code of the last accepted key

    modport master (
        input  col,
        output row,
        output num,
        output key_valid,
        output key_code
    );

    modport slave (
        output col,
        input  row,
        input  num,
        input  key_valid,
        input  key_code
    );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with frame-based debounce and a four-digit
// decimal entry register.
//
// Flow: rows are strobed one at a time for SCAN_TICKS cycles each; the
// synchronized columns are latched at the last cycle of every row slot into
// a 16-bit frame map. At the end of row 3 the completed frame is compared
// against the debounce candidate; DEBOUNCE_FRAMES identical frames commit
// the candidate to the debounced map. One cycle after a commit, a transition
// from "no keys" to "exactly one key" produces a key event and updates num.
module keypad_entry #(
    parameter int SCAN_TICKS      = 100000,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input logic      clk,
    input logic      rst,
    keypad_if.master kp
);

    localparam int CW = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_FRAMES);

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic [1:0]    row_idx;
    logic [1:0]    row_idx_next;
    logic [CW-1:0] count;
    logic [3:0]    row_q;
    logic          tick;       // last cycle of the current row slot
    logic          frame_end;  // last cycle of row 3: frame is complete

    assign row_idx_next = row_idx + 2'd1;
    assign tick         = (count == LAST_TICK);
    assign frame_end    = tick && (row_idx == 2'd3);

    // Row slot counter; the row drive moves to the next row on the same
    // edge that the current row's columns are sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            row_idx <= 2'd0;
            row_q   <= 4'b1110;
        end else if (tick) begin
            count   <= '0;
            row_idx <= row_idx_next;
            row_q   <= ~(4'b0001 << row_idx_next);
        end else begin
            count   <= count + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Column synchronizer and frame assembly
    // ------------------------------------------------------------------
    logic [3:0]  col_meta;
    logic [3:0]  col_sync;
    logic [3:0]  pressed_now;
    logic [15:0] frame_map;
    logic [15:0] new_map;

    assign pressed_now = ~col_sync;

    // Two-flop synchronizer; idles at "no column pulled low".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= 4'b1111;
            col_sync <= 4'b1111;
        end else begin
            col_meta <= kp.col;
            col_sync <= col_meta;
        end
    end

    // Latch the pressed columns of the active row at the end of its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_map <= '0;
        end else if (tick) begin
            frame_map[{row_idx, 2'b00} +: 4] <= pressed_now;
        end
    end

    // The frame as it stands after this cycle's row sample is merged in;
    // only consumed at frame_end, where the sampled row is row 3.
    always_comb begin
        new_map = frame_map;
        new_map[{row_idx, 2'b00} +: 4] = pressed_now;
    end

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [15:0]   cand;
    logic [15:0]   cand_next;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_next;
    logic [15:0]   deb;
    logic [15:0]   deb_prev;
    logic          deb_load;
    logic          deb_upd;

    // Candidate/count update for a completed frame.
    always_comb begin
        cand_next = cand;
        cnt_next  = cnt;
        if (new_map == cand) begin
            cnt_next = (cnt == DEB_MAX) ? DEB_MAX : cnt + 1'b1;
        end else begin
            cand_next = new_map;
            cnt_next  = DW'(1);
        end
    end

    assign deb_load = frame_end && (cnt_next == DEB_MAX) && (cand_next != deb);

    // Commit a stable frame to the debounced map and remember the old one
    // so the press detector can look at the transition one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand     <= '0;
            cnt      <= DEB_MAX;
            deb      <= '0;
            deb_prev <= '0;
            deb_upd  <= 1'b0;
        end else begin
            if (frame_end) begin
                cand <= cand_next;
                cnt  <= cnt_next;
            end
            if (deb_load) begin
                deb      <= cand_next;
                deb_prev <= deb;
            end
            deb_upd <= deb_load;
        end
    end

    // ------------------------------------------------------------------
    // Press detection and value entry
    // ------------------------------------------------------------------
    logic [3:0]  hit_idx;
    logic [3:0]  press_code;
    logic        press_hit;
    logic [13:0] num_q;
    logic [13:0] num_next;
    logic        key_valid_q;
    logic [3:0]  key_code_q;

    // Keypad position (4*row + col) to key code.
    function automatic logic [3:0] pos_to_code(input logic [3:0] pos);
        case (pos)
            4'd0:    pos_to_code = 4'd1;
            4'd1:    pos_to_code = 4'd2;
            4'd2:    pos_to_code = 4'd3;
            4'd3:    pos_to_code = 4'd10;
            4'd4:    pos_to_code = 4'd4;
            4'd5:    pos_to_code = 4'd5;
            4'd6:    pos_to_code = 4'd6;
            4'd7:    pos_to_code = 4'd11;
            4'd8:    pos_to_code = 4'd7;
            4'd9:    pos_to_code = 4'd8;
            4'd10:   pos_to_code = 4'd9;
            4'd11:   pos_to_code = 4'd12;
            4'd12:   pos_to_code = 4'd14;
            4'd13:   pos_to_code = 4'd0;
            4'd14:   pos_to_code = 4'd15;
            default: pos_to_code = 4'd13;
        endcase
    endfunction

    // Position of the set bit; only meaningful when deb is one-hot.
    always_comb begin
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (deb[i]) hit_idx = 4'(i);
        end
    end

    assign press_code = pos_to_code(hit_idx);
    assign press_hit  = deb_upd && (deb_prev == 16'd0) && $onehot(deb);

    // Next entered value for the accepted key: digits shift in from the
    // right dropping the top digit, '*' clears, '#' deletes the last digit.
    always_comb begin
        num_next = num_q;
        if (press_code <= 4'd9) begin
            num_next = (num_q % 14'd1000) * 14'd10 + {10'd0, press_code};
        end else if (press_code == 4'd14) begin
            num_next = 14'd0;
        end else if (press_code == 4'd15) begin
            num_next = num_q / 14'd10;
        end
    end

    // Event pulse, held key code and entered value all update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            num_q       <= 14'd0;
        end else begin
            key_valid_q <= press_hit;
            if (press_hit) begin
                key_code_q <= press_code;
                num_q      <= num_next;
            end
        end
    end

    assign kp.row       = row_q;
    assign kp.num       = num_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a combinational 4x4 keypad model.
module tb_keypad_entry;

    localparam int ST    = 4;
    localparam int DF    = 3;
    localparam int FRAME = 4 * ST;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_if kp();

    keypad_entry #(
        .SCAN_TICKS      (ST),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // ---------------- keypad model ----------------
    // col[c] is pulled low while row[r] is low and key (r,c) is held.
    logic [15:0] pressed = '0;
    logic [3:0]  col_drv;

    always_comb begin
        col_drv = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[4*r + c] && !kp.row[r]) col_drv[c] = 1'b0;
            end
        end
    end
    assign kp.col = col_drv;

    // ---------------- checking ----------------
    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Edges since the last reset release (edge 1 is the first one after it).
    int edge_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Pulse monitor, sampled on the falling edge.
    int   pulses     = 0;
    int   pulse_edge = -1;
    int   consec     = 0;
    logic kv_prev    = 1'b0;
    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) begin
            pulses++;
            pulse_edge = edge_cnt;
            if (kv_prev) consec++;
        end
        kv_prev = (kp.key_valid === 1'b1);
    end

    // ---------------- driver tasks ----------------
    function automatic int key_bit(input int code);
        case (code)
            1: key_bit = 0;   2: key_bit = 1;   3: key_bit = 2;   10: key_bit = 3;
            4: key_bit = 4;   5: key_bit = 5;   6: key_bit = 6;   11: key_bit = 7;
            7: key_bit = 8;   8: key_bit = 9;   9: key_bit = 10;  12: key_bit = 11;
            14: key_bit = 12; 0: key_bit = 13;  15: key_bit = 14; default: key_bit = 15;
        endcase
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
    endtask

    task automatic press_release(input int code);
        pressed = 16'd1 << key_bit(code);
        wait_cycles(5 * FRAME);
        pressed = '0;
        wait_cycles(5 * FRAME);
    endtask

    // ---------------- stimulus ----------------
    int base;
    int row_err;
    int exp_row;
    int hold_edge;
    int seq_num[5] = '{1, 12, 123, 1234, 2345};

    initial begin
        // Reset values while reset is held.
        wait_cycles(2);
        check("rst_row", int'(kp.row), 14);
        check("rst_num", int'(kp.num), 0);
        check("rst_key_valid", int'(kp.key_valid), 0);
        check("rst_key_code", int'(kp.key_code), 0);

        // Idle scan for 200 cycles.
        rst = 1'b0;
        row_err = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            exp_row = (~(1 << ((k / 4) % 4))) & 15;
            if (int'(kp.row) != exp_row) row_err++;
            if (k == 3 || k == 4 || k == 8 || k == 12 || k == 16)
                check($sformatf("row_seq_e%0d", k), int'(kp.row), exp_row);
        end
        check("idle_row_errors", row_err, 0);
        check("idle_pulses", pulses, 0);
        check("idle_num", int'(kp.num), 0);

        // Hold '5' from reset.
        pressed = 16'd1 << key_bit(5);
        do_reset();
        base = pulses;
        wait_cycles(48);
        check("k5_kv_e48", int'(kp.key_valid), 0);
        wait_cycles(1);
        check("k5_kv_e49", int'(kp.key_valid), 1);
        check("k5_code", int'(kp.key_code), 5);
        check("k5_num", int'(kp.num), 5);
        wait_cycles(1);
        check("k5_kv_e50", int'(kp.key_valid), 0);
        wait_cycles(10 * FRAME);
        check("k5_pulses", pulses - base, 1);
        check("k5_pulse_edge", pulse_edge, 49);
        pressed = '0;

        // Digit sequence 1..5.
        do_reset();
        base = pulses;
        for (int i = 0; i < 5; i++) begin
            press_release(i + 1);
            check($sformatf("seq_num_%0d", i + 1), int'(kp.num), seq_num[i]);
        end
        check("seq_pulses", pulses - base, 5);

        // '#', 'B', '*' from 2345.
        press_release(15);
        check("hash_num", int'(kp.num), 234);
        base = pulses;
        press_release(11);
        check("b_pulse", pulses - base, 1);
        check("b_code", int'(kp.key_code), 11);
        check("b_num", int'(kp.num), 234);
        press_release(14);
        check("star_num", int'(kp.num), 0);
        check("star_code", int'(kp.key_code), 14);

        // Bouncing '7' for 3 frames, then held.
        base = pulses;
        for (int t = 0; t < 8; t++) begin
            pressed = (t % 2 == 0) ? (16'd1 << key_bit(7)) : 16'd0;
            wait_cycles(6);
        end
        check("bounce_no_early", pulses - base, 0);
        pressed = 16'd1 << key_bit(7);
        hold_edge = edge_cnt;
        wait_cycles(5 * FRAME);
        check("bounce_pulses", pulses - base, 1);
        check("bounce_num", int'(kp.num), 7);
        check("bounce_code", int'(kp.key_code), 7);
        check("bounce_latency_ok",
              int'((pulse_edge > hold_edge) && (pulse_edge - hold_edge <= 4 * FRAME + 2)), 1);
        pressed = '0;
        wait_cycles(5 * FRAME);

        // '1' and '2' together.
        base = pulses;
        pressed = (16'd1 << key_bit(1)) | (16'd1 << key_bit(2));
        wait_cycles(5 * FRAME);
        pressed = '0;
        wait_cycles(5 * FRAME);
        check("multi_pulses", pulses - base, 0);
        check("multi_num", int'(kp.num), 7);

        // Reset while '9' is held, during the second frame of the hold.
        base = pulses;
        pressed = 16'd1 << key_bit(9);
        wait_cycles(FRAME + 4);
        rst = 1'b1;
        #1;
        check("midrst_row", int'(kp.row), 14);
        check("midrst_num", int'(kp.num), 0);
        check("midrst_kv", int'(kp.key_valid), 0);
        wait_cycles(2);
        pressed = '0;
        rst = 1'b0;
        wait_cycles(5 * FRAME);
        check("midrst_pulses", pulses - base, 0);
        check("midrst_num_after", int'(kp.num), 0);

        check("no_consecutive_kv", consec, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 matrix keypad, debounces it, and assembles a four-digit decimal number for the seven-segment multiplexer. It is the input side of the display path: the display driver takes a 14-bit value and drives digit selects out, while this block drives row selects out, reads columns back, and produces that 14-bit value. It also emits a one-cycle event per accepted keypress for other consumers.

## Interface
- SCAN_TICKS, 100000: clock cycles per row slot (1 ms at 100 MHz); must be ≥ 4
- DEBOUNCE_FRAMES, 20: consecutive identical scan frames required to accept a key-map change; must be ≥ 2
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- col  input  4  keypad columns, active-low (pulled up externally), asynchronous to clk
- row  output  4  keypad row drive, active-low, exactly one bit low at all times
- num  output  14  entered value, 0..9999, binary
- key_valid  output  1  one-cycle pulse on each accepted keypress
- key_code  output  4  code of the last accepted key, held between pulses

## Operation
- Key layout, as row r / column c → key_code:
  - r0: 1 2 3 A → 1, 2, 3, 10
  - r1: 4 5 6 B → 4, 5, 6, 11
  - r2: 7 8 9 C → 7, 8, 9, 12
  - r3: \* 0 # D → 14, 0, 15, 13
- Scanning:
  - A 2-bit row index and a counter of 0..SCAN_TICKS-1 advance the scan.
  - When count == SCAN_TICKS-1: count→0, index→index+1 (wraps 3→0), and row is registered to ~(1<<next index) in the same edge.
- Column input passes through a 2-flop synchronizer.
  - At count == SCAN_TICKS-1 of row r, pressed bits ~col_sync are written into bits [4r+3:4r] of a 16-bit frame map.
  - The sample taken in row 3 completes a frame.
- Debounce, evaluated at each frame end:
  - If the new frame map equals cand, cnt saturates upward at DEBOUNCE_FRAMES.
  - Otherwise cand takes the new map and cnt → 1.
  - When the updated cnt equals DEBOUNCE_FRAMES and cand ≠ deb, deb ← cand.
- Press detection:
  - Evaluated one cycle after a deb update.
  - If the previous deb had zero bits set and the new deb has exactly one bit set, key_valid pulses and key_code ← code.
  - Every other transition produces no event: multi-key, release, or an extra key added while one is held.
- num update, in the same cycle as the key_valid pulse:
  - digit d: num ← (num % 1000)·10 + d. The most significant digit is dropped, so num stays ≤ 9999.
  - \* (14): num ← 0.
  - \# (15): num ← num / 10.
  - A–D (10–13): num unchanged; the event is still emitted.

## Timing
- Reset values:
  - row = 4'b1110, index = 0, count = 0.
  - Synchronizer flops = 4'b1111.
  - frame map = 0, cand = 0, cnt = DEBOUNCE_FRAMES, deb = 0.
  - num = 0, key_valid = 0, key_code = 0.
- Frame period: 4·SCAN_TICKS cycles. The first frame ends on clock edge 4·SCAN_TICKS after reset deasserts.
- Press-to-event latency for a key held steadily before a frame starts:
  - deb updates at the end of the DEBOUNCE_FRAMES-th matching frame.
  - key_valid is high during the following cycle.
  - num and key_code change on that same edge.
- Bounce handling: any frame differing from cand restarts the count at 1, so a bounce lasting less than one frame delays acceptance and never duplicates it.
- Release: deb returns to 0 after DEBOUNCE_FRAMES empty frames. No event is generated; this re-arms detection.
- Reset mid-operation: all state returns to reset values immediately, the frame in progress is discarded, and no pulse is generated.
- key_valid is never high on two consecutive cycles.

## Test plan
All scenarios use SCAN_TICKS=4 and DEBOUNCE_FRAMES=3. The bench keypad model drives col[c] low combinationally while row[r] is low and key (r,c) is pressed.

- Reset then idle for 200 cycles:
  - row cycles 1110→1101→1011→0111, changing every 4 cycles.
  - num = 0, key_valid never asserts.
- Hold '5' from reset:
  - deb updates at edge 48.
  - key_valid pulses in cycle 49; key_code = 5, num = 5.
  - Holding 10 more frames produces no further pulse.
- Sequence 1,2,3,4,5, each held 5 frames and released 5 frames:
  - num after each event: 1, 12, 123, 1234, 2345.
  - Exactly 5 pulses.
- Starting from num = 2345:
  - '#' gives num = 234.
  - 'B' gives a pulse with key_code = 11 and num still 234.
  - '\*' gives num = 0.
- Bounce and multi-key:
  - '7' toggled every 6 cycles for 3 frames, then held: exactly one pulse, 3 frames after the hold starts, num = 7.
  - '1' and '2' pressed together: no pulse.
- Reset asserted while '9' is held during the second frame: num = 0, no pulse, and row = 1110 immediately.
